// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : fp_pkg                                                       |
// | Description : Shared types and helpers for the sequential FP multiplier:   |
// |               FSM state encoding, operand classes, and format-generic      |
// |               constant builders (bias, canonical qNaN, signed Inf/zero).   |
// |               Constant builders return 64-bit words; callers size-cast     |
// |               them down to their own operand width.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp_mult_state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        NORMAL = 3'd1,
        INF    = 3'd2,
        QNAN   = 3'd3,
        SNAN   = 3'd4
    } fp_class_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // {0, all-ones exponent, fraction MSB set, rest zero}
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int man_w);
        return {63'd0, sign} << (exp_w + man_w);
    endfunction

    // Denormals (exponent zero) are classed as ZERO: the core flushes them.
    function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero, input logic quiet);
        fp_class_t c;
        if (exp_zero)
            c = ZERO;
        else if (exp_ones)
            c = frac_zero ? INF : (quiet ? QNAN : SNAN);
        else
            c = NORMAL;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_ne.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_round_ne                                                  |
// | Description : Combinational normalise / round-to-nearest-even / pack for   |
// |               the raw significand product of two normal operands.          |
// | Ports       : sign      in  result sign                                    |
// |               exp_in    in  signed biased exponent ea+eb-bias              |
// |               prod      in  2*(MAN_W+1)-bit significand product            |
// |               result    out packed {sign, exp, frac}                       |
// |               overflow, underflow, inexact  out  exception flags           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_round_ne
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       sign,
    input  logic signed [EXP_W+1:0]    exp_in,
    input  logic [2*MAN_W+1:0]         prod,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       inexact
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

    logic                    w_hi;
    logic [2*MAN_W+1:0]      w_aligned;
    logic [MAN_W:0]          w_sig;
    logic                    w_guard;
    logic                    w_sticky;
    logic                    w_inc;
    logic [MAN_W+1:0]        w_sig_rnd;
    logic [MAN_W-1:0]        w_frac;
    logic signed [EXP_W+1:0] w_exp_norm;
    logic signed [EXP_W+1:0] w_exp_fin;
    logic [W-1:0]            w_pack;
    logic [W-1:0]            w_inf;
    logic [W-1:0]            w_zero;

    // Product of two [1,2) significands lies in [1,4): when the top bit is
    // clear, shift left once so the leading one always sits at the MSB.
    assign w_hi      = prod[2*MAN_W+1];
    assign w_aligned = w_hi ? prod : {prod[2*MAN_W:0], 1'b0};
    assign w_sig     = w_aligned[2*MAN_W+1:MAN_W+1];
    assign w_guard   = w_aligned[MAN_W];
    assign w_sticky  = |w_aligned[MAN_W-1:0];
    assign w_inc     = w_guard & (w_sticky | w_sig[0]);
    assign w_sig_rnd = {1'b0, w_sig} + {{(MAN_W+1){1'b0}}, w_inc};

    // A rounding carry-out leaves 10...0; renormalise by one place.
    assign w_frac     = w_sig_rnd[MAN_W+1] ? w_sig_rnd[MAN_W:1] : w_sig_rnd[MAN_W-1:0];
    assign w_exp_norm = exp_in + $signed({{(EXP_W+1){1'b0}}, w_hi});
    assign w_exp_fin  = w_exp_norm + $signed({{(EXP_W+1){1'b0}}, w_sig_rnd[MAN_W+1]});

    assign w_pack = {sign, w_exp_fin[EXP_W-1:0], w_frac};
    assign w_inf  = W'(fp_inf(sign, EXP_W, MAN_W));
    assign w_zero = W'(fp_zero(sign, EXP_W, MAN_W));

    always_comb begin
        result    = w_pack;
        overflow  = 1'b0;
        underflow = 1'b0;
        inexact   = w_guard | w_sticky;
        if (w_exp_fin >= EXP_MAX) begin
            result   = w_inf;
            overflow = 1'b1;
            inexact  = 1'b1;
        end else if (w_exp_fin <= EXP_ZERO) begin
            // No denormal outputs: anything below the normal range flushes.
            result    = w_zero;
            underflow = 1'b1;
            inexact   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fp_mult_seq                                                  |
// | Description : Sequential IEEE-754 multiplier (format set by EXP_W/MAN_W).  |
// |               Radix-2 shift-add significand multiply, one bit per cycle,   |
// |               then single-cycle normalise/RNE/pack. Specials resolve at    |
// |               accept time. Denormal inputs are flushed to zero.            |
// | Ports       : clk, rst_n (async active-low)                                |
// |               in_valid/in_ready, a, b          operand handshake           |
// |               out_valid/out_ready, result      result handshake            |
// |               overflow, underflow, invalid, inexact  flags with result     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fp_mult_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   invalid,
    output logic                   inexact
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam int CW = $clog2(MAN_W + 1);
    localparam logic signed [EXP_W+1:0] BIAS_E    = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [W-1:0]            CANON_NAN = W'(fp_qnan(EXP_W, MAN_W));

    fp_mult_state_t          r_state;
    fp_mult_state_t          w_state_next;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [SW-1:0]           r_mcand;
    logic [SW-1:0]           r_mplier;
    logic [PW-1:0]           r_prod;
    logic [CW-1:0]           r_cnt;
    logic                    r_sign;
    logic signed [EXP_W+1:0] r_exp;
    logic [W-1:0]            r_result;
    logic                    r_overflow;
    logic                    r_underflow;
    logic                    r_invalid;
    logic                    r_inexact;

    logic [EXP_W-1:0]        w_a_exp;
    logic [EXP_W-1:0]        w_b_exp;
    logic [MAN_W-1:0]        w_a_frac;
    logic [MAN_W-1:0]        w_b_frac;
    fp_class_t               w_cls_a;
    fp_class_t               w_cls_b;
    logic                    w_sign;
    logic                    w_accept;
    logic                    w_special;
    logic [W-1:0]            w_spec_result;
    logic                    w_spec_invalid;
    logic signed [EXP_W+1:0] w_exp_sum;
    logic [SW:0]             w_sum;
    logic [PW-1:0]           w_prod_next;
    logic [W-1:0]            w_rnd_result;
    logic                    w_rnd_overflow;
    logic                    w_rnd_underflow;
    logic                    w_rnd_inexact;

    assign w_a_exp  = a[W-2:MAN_W];
    assign w_b_exp  = b[W-2:MAN_W];
    assign w_a_frac = a[MAN_W-1:0];
    assign w_b_frac = b[MAN_W-1:0];
    assign w_sign   = a[W-1] ^ b[W-1];
    assign w_cls_a  = fp_classify(w_a_exp == '0, &w_a_exp, w_a_frac == '0, w_a_frac[MAN_W-1]);
    assign w_cls_b  = fp_classify(w_b_exp == '0, &w_b_exp, w_b_frac == '0, w_b_frac[MAN_W-1]);
    assign w_accept  = in_valid & r_in_ready;
    assign w_special = !((w_cls_a == NORMAL) && (w_cls_b == NORMAL));
    assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - BIAS_E;

    // Special-operand result, priority: NaN, Inf*0, Inf, zero.
    always_comb begin
        w_spec_result  = W'(fp_zero(w_sign, EXP_W, MAN_W));
        w_spec_invalid = 1'b0;
        if ((w_cls_a == QNAN) || (w_cls_a == SNAN) || (w_cls_b == QNAN) || (w_cls_b == SNAN)) begin
            w_spec_result  = CANON_NAN;
            w_spec_invalid = (w_cls_a == SNAN) || (w_cls_b == SNAN);
        end else if (((w_cls_a == INF) && (w_cls_b == ZERO)) ||
                     ((w_cls_b == INF) && (w_cls_a == ZERO))) begin
            w_spec_result  = CANON_NAN;
            w_spec_invalid = 1'b1;
        end else if ((w_cls_a == INF) || (w_cls_b == INF)) begin
            w_spec_result  = W'(fp_inf(w_sign, EXP_W, MAN_W));
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (keeping its carry), then shift the whole register right by one.
    assign w_sum       = {1'b0, r_prod[PW-1:SW]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_sum, r_prod[SW-1:1]};

    fp_round_ne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign      (r_sign),
        .exp_in    (r_exp),
        .prod      (r_prod),
        .result    (w_rnd_result),
        .overflow  (w_rnd_overflow),
        .underflow (w_rnd_underflow),
        .inexact   (w_rnd_inexact)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_special ? DONE : MUL;
            MUL:     if (r_cnt == CW'(MAN_W)) w_state_next = NORM;
            NORM:    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode so
    // in_ready stays low throughout reset and nothing is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_invalid   <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {1'b1, w_a_frac};
                        r_mplier <= {1'b1, w_b_frac};
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_sign   <= w_sign;
                        r_exp    <= w_exp_sum;
                        if (w_special) begin
                            r_result    <= w_spec_result;
                            r_invalid   <= w_spec_invalid;
                            r_overflow  <= 1'b0;
                            r_underflow <= 1'b0;
                            r_inexact   <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    r_prod   <= w_prod_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                NORM: begin
                    r_result    <= w_rnd_result;
                    r_overflow  <= w_rnd_overflow;
                    r_underflow <= w_rnd_underflow;
                    r_inexact   <= w_rnd_inexact;
                    r_invalid   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign invalid   = r_invalid;
    assign inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fp_mult_seq                                               |
// | Description : Self-checking bench for fp_mult_seq in binary32 and binary16.|
// |               Expected values come from an exact-integer product model     |
// |               rounded with remainder-vs-half comparison.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fp_mult_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic        s_in_ready, s_out_valid, s_ov, s_un, s_inv, s_inx;
    logic [31:0] s_a = '0, s_b = '0, s_result;

    logic        h_in_valid = 1'b0, h_out_ready = 1'b0;
    logic        h_in_ready, h_out_valid, h_ov, h_un, h_inv, h_inx;
    logic [15:0] h_a = '0, h_b = '0, h_result;

    fp_mult_seq #(.EXP_W(8), .MAN_W(23)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .overflow(s_ov), .underflow(s_un), .invalid(s_inv), .inexact(s_inx)
    );

    fp_mult_seq #(.EXP_W(5), .MAN_W(10)) u_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .overflow(h_ov), .underflow(h_un), .invalid(h_inv), .inexact(h_inx)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic f_ready(input bit h);
        return h ? h_in_ready : s_in_ready;
    endfunction
    function automatic logic f_valid(input bit h);
        return h ? h_out_valid : s_out_valid;
    endfunction
    function automatic logic [63:0] f_result(input bit h);
        return h ? {48'd0, h_result} : {32'd0, s_result};
    endfunction
    function automatic logic [3:0] f_flags(input bit h);
        return h ? {h_ov, h_un, h_inv, h_inx} : {s_ov, s_un, s_inv, s_inx};
    endfunction

    task automatic drv_in(input bit h, input logic [63:0] av, input logic [63:0] bv, input logic v);
        if (h) begin h_a = av[15:0]; h_b = bv[15:0]; h_in_valid = v; end
        else   begin s_a = av[31:0]; s_b = bv[31:0]; s_in_valid = v; end
    endtask
    task automatic set_ordy(input bit h, input logic v);
        if (h) h_out_ready = v; else s_out_ready = v;
    endtask

    // Reference: exact integer product, rounded by comparing the dropped
    // remainder against one half ulp. flags = {ov, un, inv, inx}.
    function automatic void ref_mul(input int ew, input int mw, input logic [63:0] av,
                                    input logic [63:0] bv, output logic [63:0] r,
                                    output logic [3:0] fl, output bit spec);
        longint unsigned emax, bias, ea, eb, fa, fb, mask, p, q, rem, half, qn, sgn, inf;
        longint e;
        int msb, sh;
        bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, up;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        mask = (64'd1 << mw) - 1;
        ea = (av >> mw) & emax;  eb = (bv >> mw) & emax;
        fa = av & mask;          fb = bv & mask;
        sgn = ((av >> (ew + mw)) ^ (bv >> (ew + mw))) & 1;
        nan_a  = (ea == emax) && (fa != 0);  nan_b = (eb == emax) && (fb != 0);
        snan_a = nan_a && (((fa >> (mw - 1)) & 1) == 0);
        snan_b = nan_b && (((fb >> (mw - 1)) & 1) == 0);
        inf_a  = (ea == emax) && (fa == 0);  inf_b = (eb == emax) && (fb == 0);
        zero_a = (ea == 0);                  zero_b = (eb == 0);
        qn  = (emax << mw) | (64'd1 << (mw - 1));
        inf = (sgn << (ew + mw)) | (emax << mw);
        fl = 4'b0000;
        spec = 1'b1;
        if (nan_a || nan_b) begin
            r = qn; fl[1] = snan_a || snan_b;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            r = qn; fl[1] = 1'b1;
        end else if (inf_a || inf_b) begin
            r = inf;
        end else if (zero_a || zero_b) begin
            r = sgn << (ew + mw);
        end else begin
            spec = 1'b0;
            p   = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
            msb = ((p >> (2 * mw + 1)) != 0) ? 2 * mw + 1 : 2 * mw;
            sh  = msb - mw;
            q   = p >> sh;
            rem = p & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up  = (rem > half) || ((rem == half) && ((q & 1) != 0));
            q   = q + (up ? 1 : 0);
            e   = longint'(ea) + longint'(eb) - longint'(bias) + longint'(msb - 2 * mw);
            if ((q >> (mw + 1)) != 0) begin q = q >> 1; e = e + 1; end
            fl[0] = (rem != 0);
            if (e >= longint'(emax)) begin
                r = inf; fl[3] = 1'b1; fl[0] = 1'b1;
            end else if (e <= 0) begin
                r = sgn << (ew + mw); fl[2] = 1'b1; fl[0] = 1'b1;
            end else begin
                r = (sgn << (ew + mw)) | (longint'(e) << mw) | (q & mask);
            end
        end
    endfunction

    function automatic logic [63:0] rnd_op(input int ew, input int mw);
        longint unsigned emax, bias, s, e, f;
        int k;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        s = longint'($urandom_range(1, 0));
        f = longint'($urandom) & ((64'd1 << mw) - 1);
        k = int'($urandom_range(9, 0));
        case (k)
            0:       begin e = 0; f = 0; end
            1:       begin e = emax; f = 0; end
            2:       begin e = emax; f = f | 1; end
            3:       begin e = 0; f = f | 1; end
            4, 5:    e = longint'($urandom_range(int'(emax) - 1, 1));
            default: e = bias - bias / 4 + longint'($urandom_range(int'(bias / 2), 0));
        endcase
        return (s << (ew + mw)) | (e << mw) | f;
    endfunction

    // One full transaction; when use_exp is set the directed constants
    // replace the model's value/flags.
    task automatic do_op(input bit h, input logic [63:0] av, input logic [63:0] bv,
                         input bit use_exp, input logic [63:0] xr, input logic [3:0] xf);
        int ew, mw, n, lat;
        logic [63:0] er;
        logic [3:0]  ef;
        bit sp;
        string tag;
        ew = h ? 5 : 8;
        mw = h ? 10 : 23;
        tag = $sformatf("%s %0h*%0h", h ? "h" : "s", av, bv);
        ref_mul(ew, mw, av, bv, er, ef, sp);
        if (use_exp) begin er = xr; ef = xf; end
        n = 0;
        while (!f_ready(h) && n < 40) begin @(posedge clk); #1; n++; end
        chk({tag, " in_ready"}, 64'(f_ready(h)), 64'd1);
        drv_in(h, av, bv, 1'b1);
        @(posedge clk); #1;
        drv_in(h, '0, '0, 1'b0);
        chk({tag, " busy"}, 64'(f_ready(h)), 64'd0);
        lat = 1;
        while (!f_valid(h) && lat < 80) begin @(posedge clk); #1; lat++; end
        chk({tag, " latency"}, 64'(lat), 64'(sp ? 1 : mw + 3));
        chk({tag, " result"}, f_result(h), er);
        chk({tag, " flags"}, 64'(f_flags(h)), 64'(ef));
        set_ordy(h, 1'b1);
        @(posedge clk); #1;
        set_ordy(h, 1'b0);
        chk({tag, " out_valid drop"}, 64'(f_valid(h)), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, hi_cnt;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 64'(s_in_ready), 64'd0);
        chk("rst out_valid", 64'(s_out_valid), 64'd0);
        chk("rst result", 64'(s_result), 64'd0);
        chk("rst flags", 64'({s_ov, s_un, s_inv, s_inx}), 64'd0);
        chk("rst h in_ready", 64'(h_in_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst in_ready", 64'(s_in_ready), 64'd1);

        // Directed binary32
        do_op(0, 64'h3FC00000, 64'h40000000, 1, 64'h40400000, 4'b0000);
        do_op(0, 64'h3F800001, 64'h3F800001, 1, 64'h3F800002, 4'b0001);
        do_op(0, 64'h7F7FFFFF, 64'h40000000, 1, 64'h7F800000, 4'b1001);
        do_op(0, 64'h00800000, 64'h3F000000, 1, 64'h00000000, 4'b0101);
        do_op(0, 64'h7F800000, 64'h80000000, 1, 64'h7FC00000, 4'b0010);
        do_op(0, 64'hFF800000, 64'h40000000, 1, 64'hFF800000, 4'b0000);
        do_op(0, 64'h7F800001, 64'h3F800000, 1, 64'h7FC00000, 4'b0010);

        // Directed binary16
        do_op(1, 64'h3E00, 64'h4000, 1, 64'h4200, 4'b0000);

        // Backpressure: result held, new operands ignored until after handshake
        drv_in(0, 64'h3FC00000, 64'h40000000, 1'b1);
        @(posedge clk); #1;
        drv_in(0, 64'h40400000, 64'h40400000, 1'b0);
        lat = 1;
        while (!s_out_valid && lat < 80) begin @(posedge clk); #1; lat++; end
        chk("bp first valid", 64'(s_out_valid), 64'd1);
        s_in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp held result", 64'(s_result), 64'h40400000);
            chk("bp held valid", 64'(s_out_valid), 64'd1);
            chk("bp in_ready low", 64'(s_in_ready), 64'd0);
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        chk("bp idle ready", 64'(s_in_ready), 64'd1);
        chk("bp idle valid", 64'(s_out_valid), 64'd0);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        chk("bp second accepted", 64'(s_in_ready), 64'd0);
        lat = 1;
        while (!s_out_valid && lat < 80) begin @(posedge clk); #1; lat++; end
        chk("bp second latency", 64'(lat), 64'd26);
        chk("bp second result", 64'(s_result), 64'h41100000);
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;

        // Reset pulse mid-MUL aborts the operation
        drv_in(0, 64'h3FC00000, 64'h40000000, 1'b1);
        @(posedge clk); #1;
        drv_in(0, '0, '0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(s_out_valid), 64'd0);
        chk("midrst in_ready", 64'(s_in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hi_cnt = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (s_out_valid) hi_cnt++;
        end
        chk("midrst no result", 64'(hi_cnt), 64'd0);
        do_op(0, 64'h3FC00000, 64'h40000000, 1, 64'h40400000, 4'b0000);

        // Randomised against the model
        for (int i = 0; i < 40; i++) do_op(0, rnd_op(8, 23), rnd_op(8, 23), 0, '0, '0);
        for (int i = 0; i < 20; i++) do_op(1, rnd_op(5, 10), rnd_op(5, 10), 0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mult_seq.md
# fp_mult_seq

Parametrised, sequential IEEE-754 binary floating-point multiplier with a valid/ready handshake on both sides. Significands are multiplied by an iterative radix-2 shift-add datapath under an FSM, then normalised and rounded to nearest-even, with special operands resolved early. It is the next-generation multiply core of the FP calculator and serves any format set by EXP_W/MAN_W, with binary32 as the default.

## Interface
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; significand is MAN_W+1 bits.
- W, derived = 1+EXP_W+MAN_W: operand/result width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a, b  in  W  operands {sign, exp, frac}.
- out_valid  out  1  result/flags valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  W  product.
- overflow, underflow, invalid, inexact  out  1 each  exception flags, valid with out_valid.

## Operation
- FSM states: IDLE, MUL, NORM, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register operands and classify them.
    - Special result → DONE.
    - Else → MUL, with the bit counter at 0.
  - MUL: each cycle, examine the LSB of the multiplier register. If set, add the multiplicand to the upper half of the 2(MAN_W+1)-bit product register. Then shift right one bit. After MAN_W+1 iterations → NORM.
  - NORM: normalise, round, and pack in one cycle → DONE.
  - DONE: out_valid=1. On out_ready → IDLE.
- Sign: a.sign XOR b.sign, including for zero and Inf results. Canonical NaN sign = 0.
- Classification and special results (denormal inputs are treated as zero, i.e. flush-to-zero):
  - NaN × any → canonical qNaN {0, all-ones, 1, 0...}.
  - Inf × 0 → qNaN with invalid=1.
  - Inf × finite nonzero → signed Inf.
  - 0 × finite → signed zero.
  - A signalling NaN input sets invalid=1. A quiet NaN input does not.
- Exponent: computed on a signed EXP_W+2-bit value, e = ea + eb − bias.
  - Product bit 2·MAN_W+1 set → take the upper significand and e+1.
  - Otherwise take the next-lower window.
- Rounding, RNE: guard = first dropped bit; sticky = OR of the remaining dropped bits; increment when guard && (sticky || lsb). inexact = guard||sticky.
  - If the increment carries out of the significand, shift right and add 1 to e.
- Overflow: final e ≥ 2^EXP_W−1 → signed Inf, overflow=1, inexact=1.
- Underflow: final e ≤ 0 → signed zero, underflow=1, inexact=1. No denormal outputs are produced.
- Reset mid-operation: the current operation is aborted and no result is emitted. The counter and datapath registers are cleared.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 after release; out_valid=0; result=0; all flags 0; state=IDLE.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.
- Latency, counted from the accepting edge to the edge after which out_valid=1:
  - Normal operands: MAN_W+3 cycles (26 for binary32, 13 for binary16).
  - Special operands: 1 cycle.
- Throughput: one operation in flight. in_ready stays low from the accept edge until the edge after out_valid&&out_ready.
- Back-to-back: the next operand is accepted no earlier than the cycle after DONE→IDLE.
- While out_valid=1 and out_ready=0, result and flags are held stable.
- in_valid while in_ready=0 is ignored. Operands are not captured.

## Structure
- Shared package fp_pkg:
  - state enum fp_mult_state_t {IDLE, MUL, NORM, DONE};
  - class enum {ZERO, NORMAL, INF, QNAN, SNAN};
  - functions for bias, the canonical qNaN, and signed Inf/zero for a given EXP_W/MAN_W.
- One sub-module, fp_round_ne: combinational normalise/RNE/pack, parametrised by EXP_W/MAN_W. It outputs the packed result plus overflow/underflow/inexact and is instantiated in NORM.

## Test plan
- Basic product: 0x3FC00000 × 0x40000000 → result 0x40400000, all flags 0, out_valid exactly 26 cycles after accept.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Overflow: 0x7F7FFFFF × 0x40000000 → 0x7F800000, overflow=1, inexact=1. Underflow: 0x00800000 × 0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Specials: 0x7F800000 × 0x80000000 → 0x7FC00000, invalid=1, latency 1. 0xFF800000 × 0x40000000 → 0xFF800000.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → result stable, in_ready=0, second operand captured only after the handshake. Drop rst_n for one cycle mid-MUL → out_valid stays 0 and the next operation is correct.
- Half precision (EXP_W=5, MAN_W=10): 0x3E00 × 0x4000 → 0x4200, latency 13.
